// File: rtl/egress_stamper_pkg.sv
// Shared definitions for the egress stamper: header field positions, packet
// limits, FSM state encoding and the packet-length legality check.
package egress_stamper_pkg;

    localparam int PACKET_XFER_LEN = 32;

    localparam int LEN_MSB  = 31;
    localparam int LEN_LSB  = 24;
    localparam int DEST_MSB = 15;
    localparam int DEST_LSB = 8;
    // Source id lives in word 2 at the same bit positions as dest in word 0
    localparam int SRC_MSB  = 15;
    localparam int SRC_LSB  = 8;

    localparam int MIN_PKT_BYTES = 24;
    localparam int END_TIME_IDX  = 5;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        WAIT_SPACE,
        EMIT
    } state_t;

    function automatic logic len_legal(input logic [7:0] len, input int max_words);
        return (len[1:0] == 2'b00) &&
               (int'(len) >= MIN_PKT_BYTES) &&
               (int'(len[7:2]) <= max_words);
    endfunction

endpackage

// File: rtl/egress_stamper_ram.sv
// Packet word buffer: one write port and one registered read port so it maps
// onto a block RAM.
module pkt_word_ram #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/egress_stamper.sv
// Buffers whole packets from the crossbar, waits for egress space, then
// replays them back-to-back with the end-time word replaced by switch time.
module egress_stamper
    import egress_stamper_pkg::*;
#(
    parameter int PACKET_XFER_LEN = egress_stamper_pkg::PACKET_XFER_LEN,
    parameter int MAX_WORDS       = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic                       in_sop,
    input  logic [PACKET_XFER_LEN-1:0] in_data,
    output logic                       in_ready,
    input  logic [31:0]                counter,
    input  logic                       egress_full,
    output logic                       out_write_en,
    output logic [PACKET_XFER_LEN-1:0] out_data,
    output logic                       busy,
    output logic                       drop_pulse,
    output logic [15:0]                drop_count
);

    localparam int AW = $clog2(MAX_WORDS);

    state_t state, state_nxt;

    logic [7:0] words_total;
    logic [7:0] wr_idx, wr_idx_nxt;
    logic [7:0] emit_idx;
    logic [7:0] rd_next;
    logic       hdr_load;
    logic       xfer;
    logic       sop_legal;
    logic [1:0] drop_inc;

    logic                       ram_we;
    logic [AW-1:0]              ram_waddr;
    logic [AW-1:0]              ram_raddr;
    logic [PACKET_XFER_LEN-1:0] ram_q_p1;

    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [1:0] inc);
        logic [16:0] s;
        s = {1'b0, a} + {15'b0, inc};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    assign in_ready  = (state == IDLE) || (state == COLLECT);
    assign busy      = (state != IDLE);
    assign xfer      = in_valid && in_ready;
    assign sop_legal = len_legal(in_data[LEN_MSB:LEN_LSB], MAX_WORDS);
    assign rd_next   = emit_idx + 8'd1;

    always_comb begin
        state_nxt  = state;
        wr_idx_nxt = wr_idx;
        hdr_load   = 1'b0;
        drop_inc   = 2'd0;
        ram_we     = 1'b0;
        ram_waddr  = wr_idx[AW-1:0];
        ram_raddr  = '0;
        case (state)
            IDLE: begin
                if (xfer && in_sop) begin
                    if (sop_legal) begin
                        ram_we     = 1'b1;
                        ram_waddr  = '0;
                        hdr_load   = 1'b1;
                        wr_idx_nxt = 8'd1;
                        state_nxt  = COLLECT;
                    end else begin
                        drop_inc = 2'd1;
                    end
                end
            end
            COLLECT: begin
                if (xfer && in_sop) begin
                    // The aborted partial packet is one drop; a bad new header is another
                    if (sop_legal) begin
                        drop_inc   = 2'd1;
                        ram_we     = 1'b1;
                        ram_waddr  = '0;
                        hdr_load   = 1'b1;
                        wr_idx_nxt = 8'd1;
                    end else begin
                        drop_inc  = 2'd2;
                        state_nxt = IDLE;
                    end
                end else if (xfer) begin
                    ram_we     = 1'b1;
                    wr_idx_nxt = wr_idx + 8'd1;
                    if (wr_idx == words_total - 8'd1) begin
                        state_nxt = WAIT_SPACE;
                    end
                end
            end
            WAIT_SPACE: begin
                // Prefetch word 0 so it is on the RAM output when EMIT starts
                if (!egress_full) begin
                    state_nxt = EMIT;
                end
            end
            EMIT: begin
                ram_raddr = rd_next[AW-1:0];
                if (emit_idx == words_total - 8'd1) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    pkt_word_ram #(
        .DATA_W(PACKET_XFER_LEN),
        .DEPTH (MAX_WORDS)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .waddr(ram_waddr),
        .wdata(in_data),
        .raddr(ram_raddr),
        .rdata(ram_q_p1)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            emit_idx   <= 8'd0;
            drop_pulse <= 1'b0;
            drop_count <= 16'd0;
        end else begin
            state      <= state_nxt;
            emit_idx   <= (state == EMIT) ? emit_idx + 8'd1 : 8'd0;
            drop_pulse <= (drop_inc != 2'd0);
            drop_count <= sat_add16(drop_count, drop_inc);
        end
    end

    always_ff @(posedge clk) begin
        wr_idx <= wr_idx_nxt;
        if (hdr_load) begin
            words_total <= {2'b00, in_data[LEN_MSB:LEN_LSB+2]};
        end
    end

    // Output stage: RAM word (or switch time at the end-time slot) registered out
    always_ff @(posedge clk) begin
        if (reset) begin
            out_write_en <= 1'b0;
            out_data     <= '0;
        end else if (state == EMIT) begin
            out_write_en <= (emit_idx == 8'd0);
            out_data     <= (emit_idx == 8'(END_TIME_IDX)) ? PACKET_XFER_LEN'(counter) : ram_q_p1;
        end else begin
            out_write_en <= 1'b0;
            out_data     <= '0;
        end
    end

endmodule

// File: tb/tb_egress_stamper.sv
// Directed bench for egress_stamper: legal, gapped, backpressured, illegal,
// early-sop and reset-during-emit packets against hand-built expected words.
module tb_egress_stamper;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_sop;
    logic [31:0] in_data;
    logic        in_ready;
    logic [31:0] counter;
    logic        egress_full;
    logic        out_write_en;
    logic [31:0] out_data;
    logic        busy;
    logic        drop_pulse;
    logic [15:0] drop_count;

    int n_checks = 0;
    int n_fail   = 0;
    int wr_en_count = 0;

    logic [31:0] pkt24a [$];
    logic [31:0] pkt24b [$];
    logic [31:0] pkt40  [$];

    egress_stamper dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_sop      (in_sop),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .counter     (counter),
        .egress_full (egress_full),
        .out_write_en(out_write_en),
        .out_data    (out_data),
        .busy        (busy),
        .drop_pulse  (drop_pulse),
        .drop_count  (drop_count)
    );

    always #5 clk = ~clk;

    // Switch time advances on the falling edge so it is stable at every rising edge
    initial begin
        counter = 32'd1000;
        forever begin
            @(negedge clk);
            counter = counter + 32'd1;
        end
    end

    always @(negedge clk) begin
        if (out_write_en === 1'b1) wr_en_count++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_sop   = 1'b0;
        end
    endtask

    task automatic send_words(input logic [31:0] w[$], input int n, input bit gap);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_sop   = (i == 0);
            in_data  = w[i];
            if (gap && i < n - 1) begin
                @(negedge clk);
                in_valid = 1'b0;
                in_sop   = 1'b0;
                in_data  = 32'hBADBAD00;
            end
        end
    endtask

    task automatic send_pkt(input logic [31:0] w[$], input bit gap);
        send_words(w, w.size(), gap);
        idle_cycles(1);
    endtask

    // Waits for word 0, checks its latency, then every following word in turn
    task automatic expect_pkt(input string tag, input logic [31:0] w[$], input int lat);
        int waited = 0;
        bit seen = 0;
        logic [31:0] exp;
        while (!seen && waited < 60) begin
            @(posedge clk); #2;
            waited++;
            if (out_write_en === 1'b1) seen = 1;
        end
        check({tag, " sop seen"}, 32'(seen), 32'd1);
        if (seen) begin
            check({tag, " latency"}, waited, lat);
            check({tag, " word0"}, out_data, w[0]);
            for (int i = 1; i < w.size(); i++) begin
                @(posedge clk); #2;
                exp = (i == 5) ? counter : w[i];
                check($sformatf("%s word%0d", tag, i), out_data, exp);
                check($sformatf("%s wen%0d", tag, i), 32'(out_write_en), 32'd0);
            end
            check({tag, " busy after"}, 32'(busy), 32'd0);
            @(posedge clk); #2;
            check({tag, " data idle"}, out_data, 32'd0);
        end
    endtask

    task automatic do_reset;
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int base;
        int waited;
        bit bad;

        pkt24a = '{32'h1800_0200, 32'h0, 32'h0000_0100, 32'h0, 32'd3, 32'd19};
        pkt24b = '{32'h1800_0500, 32'h1111_2222, 32'h0000_0700, 32'h3333_4444, 32'd50, 32'd60};
        pkt40  = '{32'h2800_0300, 32'h101, 32'h0000_0900, 32'h103, 32'd7,
                   32'hDEAD_BEEF, 32'h106, 32'h107, 32'h108, 32'h109};

        reset = 1'b1;
        in_valid = 1'b0;
        in_sop = 1'b0;
        in_data = 32'h0;
        egress_full = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("rst out_write_en", 32'(out_write_en), 32'd0);
        check("rst out_data", out_data, 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst drop_pulse", 32'(drop_pulse), 32'd0);
        check("rst drop_count", 32'(drop_count), 32'd0);
        check("rst in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        reset = 1'b0;

        // Legal contiguous 24-byte packet
        base = wr_en_count;
        send_pkt(pkt24a, 1'b0);
        expect_pkt("legal24", pkt24a, 2);
        check("legal24 pulses", wr_en_count - base, 1);

        // 40-byte packet with in_valid low every other cycle
        base = wr_en_count;
        send_pkt(pkt40, 1'b1);
        expect_pkt("gap40", pkt40, 2);
        check("gap40 pulses", wr_en_count - base, 1);

        // Egress full for 20 cycles after collection
        base = wr_en_count;
        @(negedge clk);
        egress_full = 1'b1;
        send_pkt(pkt24b, 1'b0);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #2;
            if (out_write_en !== 1'b0 || in_ready !== 1'b0) bad = 1;
        end
        check("bp held quiet", 32'(bad), 32'd0);
        check("bp in_ready", 32'(in_ready), 32'd0);
        check("bp busy", 32'(busy), 32'd1);
        @(negedge clk);
        egress_full = 1'b0;
        expect_pkt("bp24", pkt24b, 2);
        check("bp pulses", wr_en_count - base, 1);

        // Illegal lengths 22 and 20
        base = wr_en_count;
        @(negedge clk);
        in_valid = 1'b1; in_sop = 1'b1; in_data = 32'h1600_0200;
        @(posedge clk); #2;
        check("ill22 drop_pulse", 32'(drop_pulse), 32'd1);
        @(negedge clk);
        in_valid = 1'b0; in_sop = 1'b0;
        @(posedge clk); #2;
        check("ill22 pulse width", 32'(drop_pulse), 32'd0);
        @(negedge clk);
        in_valid = 1'b1; in_sop = 1'b1; in_data = 32'h1400_0200;
        @(posedge clk); #2;
        check("ill20 drop_pulse", 32'(drop_pulse), 32'd1);
        idle_cycles(10);
        check("ill drop_count", 32'(drop_count), 32'd2);
        check("ill no emit", wr_en_count - base, 0);
        check("ill busy", 32'(busy), 32'd0);

        // Early sop: 40-byte packet cut after 4 words, then a full 24-byte packet
        do_reset();
        check("early rst drop_count", 32'(drop_count), 32'd0);
        base = wr_en_count;
        send_words(pkt40, 4, 1'b0);
        send_pkt(pkt24b, 1'b0);
        expect_pkt("early24", pkt24b, 2);
        check("early drop_count", 32'(drop_count), 32'd1);
        check("early pulses", wr_en_count - base, 1);

        // Reset in the middle of emission
        base = wr_en_count;
        send_pkt(pkt24a, 1'b0);
        waited = 0;
        while (out_write_en !== 1'b1 && waited < 60) begin
            @(posedge clk); #2;
            waited++;
        end
        check("mid sop seen", 32'(out_write_en), 32'd1);
        @(posedge clk); #2;
        check("mid word1", out_data, pkt24a[1]);
        @(posedge clk); #2;
        check("mid word2", out_data, pkt24a[2]);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #2;
        check("mid rst wen", 32'(out_write_en), 32'd0);
        check("mid rst data", out_data, 32'd0);
        check("mid rst busy", 32'(busy), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #2;
            if (out_data !== 32'd0) bad = 1;
        end
        check("mid quiet data", 32'(bad), 32'd0);
        check("mid pulses", wr_en_count - base, 1);
        check("mid in_ready", 32'(in_ready), 32'd1);

        base = wr_en_count;
        send_pkt(pkt24b, 1'b0);
        expect_pkt("after rst", pkt24b, 2);
        check("after rst pulses", wr_en_count - base, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
